// File: rtl/dfi_rddata_buffer.sv
// DFI read-data capture buffer: packs aligned per-phase read beats into a FIFO with credit-based flow control.
// Optional saturating error counter (err_cnt_o) is compiled in with `define DFI_RDBUF_ERRCNT_EN.
module dfi_rddata_buffer #(
    parameter int NPHASES = 8,
    parameter int DW      = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPHASES*DW-1:0]        dfi_rddata_i,
    input  logic [NPHASES-1:0]           dfi_rddata_valid_i,
    input  logic                         rd_issue_i,
    output logic                         credit_o,
    output logic                         rd_valid_o,
    output logic [NPHASES*DW-1:0]        rd_data_o,
    input  logic                         rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         err_partial_o,
    output logic                         err_unexp_o,
    output logic                         ovf_o,
    output logic                         issue_err_o,
    input  logic                         clear_i
`ifdef DFI_RDBUF_ERRCNT_EN
   ,output logic [15:0]                  err_cnt_o
`endif
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [NPHASES*DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, out_q, out_d;
    logic          credit_q, credit_d;
    logic          partial_q, partial_d, unexp_q, unexp_d;
    logic          ovf_q, ovf_d, ierr_q, ierr_d;
    logic          cap, full_beat, fifo_full, push, pop, drop;

    always_comb begin
        cap       = |dfi_rddata_valid_i;
        full_beat = &dfi_rddata_valid_i;
        fifo_full = (level_q == DEPTH_L);
        pop       = (level_q != '0) && rd_ready_i;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = full_beat && (!fifo_full || pop);
        drop      = full_beat && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + ONE_P : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ONE_P : rd_ptr_q;

        level_d = level_q;
        if (push && !pop)
            level_d = level_q + ONE_L;
        else if (pop && !push)
            level_d = level_q - ONE_L;

        out_d = out_q;
        if (rd_issue_i && !cap) begin
            if (out_q != DEPTH_L)
                out_d = out_q + ONE_L;
        end else if (cap && !rd_issue_i) begin
            if (out_q != '0)
                out_d = out_q - ONE_L;
        end

        credit_d  = ({1'b0, out_d} + {1'b0, level_d}) < {1'b0, DEPTH_L};
        partial_d = cap && !full_beat;
        unexp_d   = cap && (out_q == '0);

        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (clear_i)
            ovf_d = 1'b0;

        ierr_d = ierr_q;
        if (rd_issue_i && !credit_q)
            ierr_d = 1'b1;
        else if (clear_i)
            ierr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            out_q     <= '0;
            credit_q  <= 1'b1;
            partial_q <= 1'b0;
            unexp_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ierr_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            out_q     <= out_d;
            credit_q  <= credit_d;
            partial_q <= partial_d;
            unexp_q   <= unexp_d;
            ovf_q     <= ovf_d;
            ierr_q    <= ierr_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks whatever the entries hold.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= dfi_rddata_i;
    end

    assign rd_valid_o    = (level_q != '0);
    assign rd_data_o     = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o       = level_q;
    assign credit_o      = credit_q;
    assign err_partial_o = partial_q;
    assign err_unexp_o   = unexp_q;
    assign ovf_o         = ovf_q;
    assign issue_err_o   = ierr_q;

`ifdef DFI_RDBUF_ERRCNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cnt_inc;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_inc = {1'b0, partial_d} + {1'b0, unexp_d} + {1'b0, drop};
        // Events in the clearing cycle still count, matching the sticky flags.
        cnt_sum = {1'b0, (clear_i ? 16'h0000 : cnt_q)} + {15'h0000, cnt_inc};
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign err_cnt_o = cnt_q;
`endif

endmodule
